// File: rtl/alu_bcd_if.sv
// Request/response bundle for the decimal-mode ADC/SBC unit: operands and
// status in, busy/done handshake plus registered result and status out.
interface alu_bcd_if;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] flag_in;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic [7:0] flag_out;

  modport master (
    output start, sub, a, b, flag_in,
    input  busy, done, out, flag_out
  );

  modport slave (
    input  start, sub, a, b, flag_in,
    output busy, done, out, flag_out
  );
endinterface

// File: rtl/alu_bcd.sv
// Multi-cycle 6502-style decimal ADC/SBC: low digit in LO, high digit and
// flags in HI, result presented with a one-cycle DONE pulse in FIN.
module alu_bcd (
  input  logic     clk,
  input  logic     rst,
  alu_bcd_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

  state_t            state_q, state_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic              sub_q, sub_d;
  logic [7:0]        flag_q, flag_d;
  logic signed [6:0] al_q, al_d;
  logic [7:0]        out_q, out_d;
  logic [7:0]        flag_out_q, flag_out_d;

  logic              accept;
  logic [10:0]       hi_res;
  logic [7:0]        bin8;
  logic              z_flag;
  logic              unused_flag_bits;

  // Low-nibble add/subtract with decimal adjust; carry/borrow into the high
  // digit is encoded as +0x10 / -0x10 in the returned value.
  function automatic logic signed [6:0] bcd_lo(input logic [3:0] an,
                                              input logic [3:0] bn,
                                              input logic       cin,
                                              input logic       sub);
    logic signed [6:0] t;
    logic signed [6:0] adj;
    if (!sub) begin
      t = $signed({3'b000, an}) + $signed({3'b000, bn}) + $signed({6'b0, cin});
      if (t >= 7'sd10) begin
        adj = t + 7'sd6;
        t   = $signed({3'b001, adj[3:0]});
      end
    end else begin
      t = $signed({3'b000, an}) - $signed({3'b000, bn}) + $signed({6'b0, cin}) - 7'sd1;
      if (t < 7'sd0) begin
        adj = t - 7'sd6;
        t   = $signed({3'b111, adj[3:0]});
      end
    end
    return t;
  endfunction

  // High-digit combine and adjust; returns {C, N, V, OUT}.
  function automatic logic [10:0] bcd_hi(input logic [7:0]        a,
                                         input logic [7:0]        b,
                                         input logic signed [6:0] al,
                                         input logic              cin,
                                         input logic              sub);
    logic signed [10:0] s;
    logic signed [10:0] vs;
    logic signed [10:0] alx;
    logic [8:0]         bin;
    logic               c, n, v;
    alx = $signed({{4{al[6]}}, al});
    vs  = '0;
    bin = '0;
    if (!sub) begin
      s  = $signed({3'b000, a[7:4], 4'b0000}) + $signed({3'b000, b[7:4], 4'b0000}) + alx;
      vs = $signed({{3{a[7]}}, a[7:4], 4'b0000}) + $signed({{3{b[7]}}, b[7:4], 4'b0000}) + alx;
      n  = s[7];
      v  = (vs > 11'sd127) || (vs < -11'sd128);
      if (s >= 11'sd160) s = s + 11'sd96;
      c  = (s >= 11'sd256);
    end else begin
      s = $signed({3'b000, a[7:4], 4'b0000}) - $signed({3'b000, b[7:4], 4'b0000}) + alx;
      if (s < 11'sd0) s = s - 11'sd96;
      bin = {1'b0, a} - {1'b0, b} - {8'b0, ~cin};
      c   = ~bin[8];
      n   = bin[7];
      v   = (a[7] ^ b[7]) & (a[7] ^ bin[7]);
    end
    return {c, n, v, s[7:0]};
  endfunction

  assign accept = ((state_q == IDLE) || (state_q == FIN)) && bus.start;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, FIN: state_d = bus.start ? LO : IDLE;
      LO:        state_d = HI;
      HI:        state_d = FIN;
      default:   state_d = IDLE;
    endcase
  end

  // Operand latch: only written when a request is accepted.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sub_d  = sub_q;
    flag_d = flag_q;
    if (accept) begin
      a_d    = bus.a;
      b_d    = bus.b;
      sub_d  = bus.sub;
      flag_d = bus.flag_in;
    end
  end

  // Stage LO: low digit
  always_comb begin
    al_d = al_q;
    if (state_q == LO) al_d = bcd_lo(a_q[3:0], b_q[3:0], flag_q[0], sub_q);
  end

  // Stage HI: high digit, flags, result register
  always_comb begin
    hi_res = bcd_hi(a_q, b_q, al_q, flag_q[0], sub_q);
    // Z follows the plain binary result, not the decimal-adjusted one.
    bin8   = sub_q ? (a_q - b_q - {7'b0, ~flag_q[0]})
                   : (a_q + b_q + {7'b0, flag_q[0]});
    z_flag = (bin8 == 8'h00);
    out_d      = out_q;
    flag_out_d = flag_out_q;
    if (state_q == HI) begin
      out_d      = hi_res[7:0];
      flag_out_d = {hi_res[9], hi_res[8], flag_q[5:2], z_flag, hi_res[10]};
    end
  end

  assign unused_flag_bits = ^{flag_q[7:6], flag_q[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      flag_q     <= '0;
      al_q       <= '0;
      out_q      <= '0;
      flag_out_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      flag_q     <= flag_d;
      al_q       <= al_d;
      out_q      <= out_d;
      flag_out_q <= flag_out_d;
    end
  end

  assign bus.busy     = (state_q == LO) || (state_q == HI);
  assign bus.done     = (state_q == FIN);
  assign bus.out      = out_q;
  assign bus.flag_out = flag_out_q;

endmodule

// File: tb/tb_alu_bcd.sv
// Directed bench for alu_bcd: hand-computed decimal ADC/SBC vectors, latency,
// START filtering, back-to-back issue and reset abort.
module tb_alu_bcd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_bcd_if bus();

  alu_bcd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s, input logic [7:0] ai, input logic [7:0] bi,
                       input logic [7:0] fi);
    bus.start   = 1'b1;
    bus.sub     = s;
    bus.a       = ai;
    bus.b       = bi;
    bus.flag_in = fi;
  endtask

  // Advances until DONE is seen (bounded); cyc = edges taken.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.start = 1'b0;
      cyc++;
      if (bus.done === 1'b1) return;
    end
    cyc = -1;
  endtask

  task automatic run_op(input string name, input logic s, input logic [7:0] ai,
                        input logic [7:0] bi, input logic [7:0] fi,
                        input logic [7:0] exp_out, input logic [7:0] exp_flag);
    int cyc;
    issue(s, ai, bi, fi);
    wait_done(cyc);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected 3", name, cyc);
    end
    checks++;
    if (bus.out !== exp_out) begin
      errors++;
      $display("FAIL %s out: got %h, expected %h", name, bus.out, exp_out);
    end
    checks++;
    if (bus.flag_out !== exp_flag) begin
      errors++;
      $display("FAIL %s flag_out: got %h, expected %h", name, bus.flag_out, exp_flag);
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.flag_in = '0;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.busy, bus.done, bus.out, bus.flag_out} !== 18'h0) begin
      errors++;
      $display("FAIL reset outputs: got busy=%b done=%b out=%h flag=%h, expected all 0",
               bus.busy, bus.done, bus.out, bus.flag_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_adc;
    run_op("adc_58_46", 1'b0, 8'h58, 8'h46, 8'h00, 8'h04, 8'hC1);
    run_op("adc_99_01", 1'b0, 8'h99, 8'h01, 8'h00, 8'h00, 8'h81);
    run_op("adc_12_34_c", 1'b0, 8'h12, 8'h34, 8'h01, 8'h47, 8'h00);
    run_op("adc_zero", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02);
    run_op("adc_invalid", 1'b0, 8'h0F, 8'h01, 8'h00, 8'h16, 8'h00);
    run_op("adc_flag_pass", 1'b0, 8'h01, 8'h01, 8'h3C, 8'h02, 8'h3C);
  endtask

  task automatic test_sbc;
    run_op("sbc_46_12", 1'b1, 8'h46, 8'h12, 8'h01, 8'h34, 8'h01);
    run_op("sbc_40_13", 1'b1, 8'h40, 8'h13, 8'h01, 8'h27, 8'h01);
    run_op("sbc_12_34", 1'b1, 8'h12, 8'h34, 8'h01, 8'h78, 8'h80);
    run_op("sbc_50_50", 1'b1, 8'h50, 8'h50, 8'h01, 8'h00, 8'h03);
    run_op("sbc_20_05_b", 1'b1, 8'h20, 8'h05, 8'h00, 8'h14, 8'h01);
  endtask

  task automatic test_ignore_start;
    issue(1'b0, 8'h12, 8'h34, 8'h01);
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL ign_lo busy/done: got %b/%b, expected 1/0", bus.busy, bus.done);
    end
    issue(1'b1, 8'h99, 8'h99, 8'h00);
    tick();
    issue(1'b1, 8'h77, 8'h11, 8'h00);
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.out !== 8'h47 || bus.flag_out !== 8'h00) begin
      errors++;
      $display("FAIL ign_result: got done=%b out=%h flag=%h, expected 1 47 00",
               bus.done, bus.out, bus.flag_out);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_idle: got done=%b busy=%b, expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    run_op("b2b_first", 1'b0, 8'h58, 8'h46, 8'h00, 8'h04, 8'hC1);
    issue(1'b1, 8'h46, 8'h12, 8'h01);
    wait_done(cyc);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles, expected 3", cyc);
    end
    checks++;
    if (bus.out !== 8'h34 || bus.flag_out !== 8'h01) begin
      errors++;
      $display("FAIL b2b_second: got out=%h flag=%h, expected 34 01", bus.out, bus.flag_out);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    issue(1'b0, 8'h12, 8'h34, 8'h01);
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.out, bus.flag_out} !== 18'h0) begin
      errors++;
      $display("FAIL abort_state: got busy=%b done=%b out=%h flag=%h, expected all 0",
               bus.busy, bus.done, bus.out, bus.flag_out);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses, expected 0", seen);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_op("post_reset", 1'b0, 8'h01, 8'h01, 8'h3C, 8'h02, 8'h3C);
  endtask

  initial begin
    test_reset();
    test_adc();
    test_sbc();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
